// File: rtl/op_pkg.sv
// Shared op encodings and dispatcher state type, common to the switch decoder
// and the op dispatcher.
package op_pkg;

  localparam int unsigned NUM_OPS = 5;

  typedef enum logic [2:0] {
    OP_NONE      = 3'd0,
    OP_MAT_INPUT = 3'd1,
    OP_GEN       = 3'd2,
    OP_SHOW      = 3'd3,
    OP_CALC      = 3'd4,
    OP_SETTINGS  = 3'd5
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    RUN
  } disp_state_t;

  // Bit k set for op code k+1; codes 0, 6 and 7 map to all-zero.
  function automatic logic [NUM_OPS-1:0] op_onehot(input logic [2:0] code);
    logic [NUM_OPS-1:0] v;
    v = '0;
    for (int unsigned k = 0; k < NUM_OPS; k++) begin
      if (code == 3'(k + 1)) v[k] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic op_is_valid(input logic [2:0] code);
    return (code >= 3'(OP_MAT_INPUT)) && (code <= 3'(OP_SETTINGS));
  endfunction

endpackage

// File: rtl/op_stabilizer.sv
// Hold filter: accepts op as stable_op once it has stayed unchanged for
// STABLE_CYCLES consecutive cycles.
module op_stabilizer
  import op_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] op,
  output logic [2:0] stable_op,
  output logic       stable
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);

  logic [2:0]    prev_op;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;

  always_comb begin
    cnt_n = cnt;
    if (op != prev_op) begin
      cnt_n = '0;
    end else if (cnt != CMAX) begin
      cnt_n = cnt + CW'(1);
    end
  end

  // stable is registered alongside the counter so it tracks cnt_n exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_op   <= '0;
      cnt       <= '0;
      stable_op <= '0;
      stable    <= 1'b0;
    end else begin
      prev_op <= op;
      cnt     <= cnt_n;
      stable  <= (cnt_n == CMAX);
      if (cnt_n == CMAX) stable_op <= op;
    end
  end

endmodule

// File: rtl/op_dispatcher.sv
// Launches the selected functional unit on confirm and tracks it until done,
// abort, op change or timeout. All outputs are registered.
module op_dispatcher
  import op_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned CNT_W          = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         op,
  input  logic               confirm,
  input  logic               abort,
  input  logic [NUM_OPS-1:0] done_i,
  output logic [NUM_OPS-1:0] start_o,
  output logic [2:0]         active_op,
  output logic               busy,
  output logic               done_o,
  output logic               abort_o,
  output logic               err_invalid,
  output logic               err_timeout
);

  localparam logic [CNT_W-1:0] TO_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0] stable_op;
  logic       stable;

  op_stabilizer #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_stab (
    .clk      (clk),
    .rst      (rst),
    .op       (op),
    .stable_op(stable_op),
    .stable   (stable)
  );

  disp_state_t        state, state_n;
  logic [CNT_W-1:0]   tcnt, tcnt_n;
  logic [NUM_OPS-1:0] start_n;
  logic [2:0]         active_n;
  logic               busy_n, done_n, abort_n, err_inv_n, err_to_n;

  always_comb begin
    state_n   = state;
    tcnt_n    = tcnt;
    start_n   = '0;
    active_n  = active_op;
    busy_n    = busy;
    done_n    = 1'b0;
    abort_n   = 1'b0;
    err_inv_n = 1'b0;
    err_to_n  = 1'b0;
    case (state)
      IDLE: begin
        busy_n   = 1'b0;
        active_n = '0;
        if (confirm) begin
          if (stable && op_is_valid(stable_op)) begin
            state_n  = LAUNCH;
            active_n = stable_op;
            start_n  = op_onehot(stable_op);
            busy_n   = 1'b1;
          end else begin
            err_inv_n = 1'b1;
          end
        end
      end
      LAUNCH: begin
        state_n = RUN;
        busy_n  = 1'b1;
        tcnt_n  = '0;
      end
      RUN: begin
        busy_n = 1'b1;
        // Exit priority: completion, then cancel/op change, then timeout.
        if (|(done_i & op_onehot(active_op))) begin
          done_n   = 1'b1;
          state_n  = IDLE;
          busy_n   = 1'b0;
          active_n = '0;
        end else if (abort || (stable && (stable_op != active_op))) begin
          abort_n  = 1'b1;
          state_n  = IDLE;
          busy_n   = 1'b0;
          active_n = '0;
        end else if ((TIMEOUT_CYCLES != 0) && (tcnt == TO_LAST)) begin
          err_to_n = 1'b1;
          state_n  = IDLE;
          busy_n   = 1'b0;
          active_n = '0;
        end else begin
          tcnt_n = tcnt + CNT_W'(1);
        end
      end
      default: begin
        state_n  = IDLE;
        busy_n   = 1'b0;
        active_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tcnt        <= '0;
      start_o     <= '0;
      active_op   <= '0;
      busy        <= 1'b0;
      done_o      <= 1'b0;
      abort_o     <= 1'b0;
      err_invalid <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      tcnt        <= tcnt_n;
      start_o     <= start_n;
      active_op   <= active_n;
      busy        <= busy_n;
      done_o      <= done_n;
      abort_o     <= abort_n;
      err_invalid <= err_inv_n;
      err_timeout <= err_to_n;
    end
  end

endmodule

// File: tb/tb_op_dispatcher.sv
// Directed self-checking bench for op_dispatcher with STABLE_CYCLES=4,
// TIMEOUT_CYCLES=20.
module tb_op_dispatcher;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] op;
  logic       confirm;
  logic       abort;
  logic [4:0] done_i;
  logic [4:0] start_o;
  logic [2:0] active_op;
  logic       busy, done_o, abort_o, err_invalid, err_timeout;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  op_dispatcher #(
    .STABLE_CYCLES (4),
    .TIMEOUT_CYCLES(20),
    .CNT_W         (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .confirm    (confirm),
    .abort      (abort),
    .done_i     (done_i),
    .start_o    (start_o),
    .active_op  (active_op),
    .busy       (busy),
    .done_o     (done_o),
    .abort_o    (abort_o),
    .err_invalid(err_invalid),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packs every output: {start_o, active_op, busy, done_o, abort_o, err_invalid, err_timeout}
  function automatic logic [31:0] outs();
    return {19'd0, start_o, active_op, busy, done_o, abort_o, err_invalid, err_timeout};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1'b1; op = 3'd0; confirm = 1'b0; abort = 1'b0; done_i = '0;
    tick(); tick();
    check("reset_outputs", outs(), 32'd0);
    rst = 1'b0;

    // Launch op 3, complete after a few RUN cycles
    op = 3'd3;
    repeat (5) tick();
    confirm = 1'b1; tick(); confirm = 1'b0;
    check("launch3_start", 32'(start_o), 32'h04);
    check("launch3_busy", 32'(busy), 32'd1);
    check("launch3_active", 32'(active_op), 32'd3);
    tick();
    check("launch3_start_low", 32'(start_o), 32'h00);
    check("launch3_run_busy", 32'(busy), 32'd1);
    repeat (3) tick();
    done_i = 5'b00100; tick(); done_i = '0;
    check("done3_pulse", 32'(done_o), 32'd1);
    check("done3_busy", 32'(busy), 32'd0);
    check("done3_active", 32'(active_op), 32'd0);
    tick();
    check("done3_pulse_end", 32'(done_o), 32'd0);

    // Confirm before op is stable
    op = 3'd2;
    repeat (2) tick();
    confirm = 1'b1; tick(); confirm = 1'b0;
    check("unstable_err", 32'(err_invalid), 32'd1);
    check("unstable_start", 32'(start_o), 32'd0);
    check("unstable_busy", 32'(busy), 32'd0);
    tick();
    check("unstable_err_end", 32'(err_invalid), 32'd0);

    // Stable but invalid op 0
    op = 3'd0;
    repeat (5) tick();
    confirm = 1'b1; tick(); confirm = 1'b0;
    check("op0_err", 32'(err_invalid), 32'd1);
    check("op0_start", 32'(start_o), 32'd0);
    tick();

    // Op 4: wrong-unit done ignored, done beats abort
    op = 3'd4;
    repeat (5) tick();
    confirm = 1'b1; tick(); confirm = 1'b0;
    check("launch4_start", 32'(start_o), 32'h08);
    tick();
    done_i = 5'b00001; tick(); done_i = '0;
    check("wrong_done_busy", 32'(busy), 32'd1);
    check("wrong_done_pulse", 32'(done_o), 32'd0);
    abort = 1'b1; done_i = 5'b01000; tick(); abort = 1'b0; done_i = '0;
    check("done_vs_abort_done", 32'(done_o), 32'd1);
    check("done_vs_abort_abort", 32'(abort_o), 32'd0);
    check("done_vs_abort_busy", 32'(busy), 32'd0);
    tick();
    abort = 1'b1; tick(); abort = 1'b0;
    check("idle_abort_noeffect", outs(), 32'd0);

    // Op 1 running; op switches to 5 and settles -> cancel, then relaunch 5
    op = 3'd1;
    repeat (5) tick();
    confirm = 1'b1; tick(); confirm = 1'b0;
    check("launch1_start", 32'(start_o), 32'h01);
    tick();
    op = 3'd5;
    repeat (5) tick();
    check("opchg_no_abort_yet", 32'(abort_o), 32'd0);
    check("opchg_still_busy", 32'(busy), 32'd1);
    tick();
    check("opchg_abort", 32'(abort_o), 32'd1);
    check("opchg_busy", 32'(busy), 32'd0);
    check("opchg_active", 32'(active_op), 32'd0);
    confirm = 1'b1; tick(); confirm = 1'b0;
    check("relaunch5_start", 32'(start_o), 32'h10);
    check("relaunch5_active", 32'(active_op), 32'd5);
    tick();
    done_i = 5'b10000; tick(); done_i = '0;
    check("done5_pulse", 32'(done_o), 32'd1);
    tick();

    // Op 2 runs into the 20-cycle timeout; confirm mid-run is ignored
    op = 3'd2;
    repeat (5) tick();
    confirm = 1'b1; tick(); confirm = 1'b0;
    check("launch2_start", 32'(start_o), 32'h02);
    tick();
    for (int i = 1; i <= 19; i++) begin
      confirm = (i == 3);
      tick();
      confirm = 1'b0;
      if (i == 3 || i == 19) begin
        check("run_no_start", 32'(start_o), 32'd0);
        check("run_no_err", 32'({err_invalid, err_timeout}), 32'd0);
        check("run_busy", 32'(busy), 32'd1);
      end
    end
    tick();
    check("timeout_pulse", 32'(err_timeout), 32'd1);
    check("timeout_busy", 32'(busy), 32'd0);
    check("timeout_active", 32'(active_op), 32'd0);
    tick();
    check("timeout_pulse_end", 32'(err_timeout), 32'd0);

    // Reset mid-run, then confirm before the filter settles
    op = 3'd3;
    repeat (5) tick();
    confirm = 1'b1; tick(); confirm = 1'b0;
    tick(); tick();
    check("prereset_busy", 32'(busy), 32'd1);
    rst = 1'b1; tick();
    check("midrun_reset_outputs", outs(), 32'd0);
    rst = 1'b0;
    tick();
    confirm = 1'b1; tick(); confirm = 1'b0;
    check("postreset_err", 32'(err_invalid), 32'd1);
    check("postreset_start", 32'(start_o), 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
